// File: rtl/l1_cache_ctrl_pkg.sv
// Shared definitions for the BEAN L1 data cache controller.
//  - default cache geometry (word width, address width, line size, set count)
//  - FSM state encodings, kept as plain 3-bit constants so older tooling and
//    debug scripts can decode the exposed state directly.
package l1_cache_ctrl_pkg;

   localparam int L1_XLEN       = 32;
   localparam int L1_ADDR_W     = 32;
   localparam int L1_LINE_WORDS = 4;
   localparam int L1_SETS       = 64;

   localparam int ST_W = 3;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_WB_RD   = 3'd2;
   localparam logic [2:0] S_WB_REQ  = 3'd3;
   localparam logic [2:0] S_RF_REQ  = 3'd4;
   localparam logic [2:0] S_RF_WAIT = 3'd5;
   localparam logic [2:0] S_REPLAY  = 3'd6;

endpackage

// File: rtl/l1_tag_array.sv
// Tag / valid / dirty storage for the direct-mapped L1 data cache.
// Ports:
//  clk, rst      core clock; synchronous active-high reset clears every
//                valid and dirty bit (tags are left as they are)
//  rd_idx        set index to look up (combinational read)
//  rd_tag        stored tag of that set
//  rd_valid      valid bit of that set
//  rd_dirty      dirty bit of that set
//  wr_en         write strobe: set wr_idx to {wr_tag, valid=1, wr_dirty}
//  wr_idx        set index to write
//  wr_tag        tag to store
//  wr_dirty      dirty bit to store
module l1_tag_array
   import l1_cache_ctrl_pkg::*;
#(
   parameter int TAG_W = 22,
   parameter int IDX_W = 6,
   parameter int SETS  = L1_SETS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [TAG_W-1:0] rd_tag,
   output logic             rd_valid,
   output logic             rd_dirty,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             wr_dirty
);

   logic [TAG_W-1:0] tag_q [SETS];
   logic [SETS-1:0]  valid_q;
   logic [SETS-1:0]  dirty_q;

   // Every write leaves the set valid: it is either a store hit (already
   // valid) or the completion of a refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   // Tags need no reset: a set is only ever trusted through its valid bit.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         tag_q[wr_idx] <= wr_tag;
      end
   end

   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/l1_cache_ctrl.sv
// Controller for the BEAN L1 data cache: direct-mapped, write-back,
// write-allocate, one CPU request and one memory beat in flight.
// Ports:
//  clk, rst                  core clock, synchronous active-high reset
//  cpu_req_valid/ready       CPU request handshake (ready only in IDLE)
//  cpu_req_we/addr/wdata     store flag, byte address, store data
//  cpu_resp_valid/data       one-cycle completion pulse, load data
//  dat_addr/we/wdata/rdata   external single-ported data SRAM, {index,word}
//                            addressing, read data one cycle after address
//  mem_req_valid/ready       memory beat handshake (transfer on valid&ready)
//  mem_req_we/addr/wdata     beat direction, word address, write data
//  mem_resp_valid/data       read beat return
//  dbg_state                 current FSM state (encodings in the package)
//
// Handshake rule for both request channels: a transfer happens on a rising
// clock edge where valid and ready are both high; once the controller raises
// mem_req_valid it holds mem_req_we/addr/wdata unchanged until that edge.
module l1_cache_ctrl
   import l1_cache_ctrl_pkg::*;
#(
   parameter  int XLEN       = L1_XLEN,
   parameter  int ADDR_W     = L1_ADDR_W,
   parameter  int LINE_WORDS = L1_LINE_WORDS,
   parameter  int SETS       = L1_SETS,
   localparam int BYTE_W     = $clog2(XLEN / 8),
   localparam int WSEL_W     = $clog2(LINE_WORDS),
   localparam int OFF_W      = WSEL_W + BYTE_W,
   localparam int IDX_W      = $clog2(SETS),
   localparam int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req_valid,
   output logic                    cpu_req_ready,
   input  logic                    cpu_req_we,
   input  logic [ADDR_W-1:0]       cpu_req_addr,
   input  logic [XLEN-1:0]         cpu_req_wdata,
   output logic                    cpu_resp_valid,
   output logic [XLEN-1:0]         cpu_resp_data,
   output logic [IDX_W+WSEL_W-1:0] dat_addr,
   output logic                    dat_we,
   output logic [XLEN-1:0]         dat_wdata,
   input  logic [XLEN-1:0]         dat_rdata,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_we,
   output logic [ADDR_W-1:0]       mem_req_addr,
   output logic [XLEN-1:0]         mem_req_wdata,
   input  logic                    mem_resp_valid,
   input  logic [XLEN-1:0]         mem_resp_data,
   output logic [ST_W-1:0]         dbg_state
);

   localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

   logic [ST_W-1:0]          state, state_d;
   logic [WSEL_W-1:0]        cnt;
   logic                     req_we;
   logic [ADDR_W-1:BYTE_W]   req_addr;
   logic [XLEN-1:0]          req_wdata;
   logic [XLEN-1:0]          wb_data;
   logic                     wb_fresh;

   logic [IDX_W-1:0]  req_idx;
   logic [WSEL_W-1:0] req_word;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  cpu_idx;
   logic [WSEL_W-1:0] cpu_word;

   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              rd_dirty;
   logic              hit;
   logic              cnt_last;
   logic              tag_we;
   logic              tag_wr_dirty;

   // Byte-within-word bits carry no information for full-word accesses.
   logic              unused_byte_bits;
   assign unused_byte_bits = ^cpu_req_addr[BYTE_W-1:0];

   assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
   assign req_word = req_addr[OFF_W-1:BYTE_W];
   assign req_tag  = req_addr[ADDR_W-1:OFF_W+IDX_W];
   assign cpu_idx  = cpu_req_addr[OFF_W+IDX_W-1:OFF_W];
   assign cpu_word = cpu_req_addr[OFF_W-1:BYTE_W];

   assign hit       = rd_valid && (rd_tag == req_tag);
   assign cnt_last  = (cnt == LAST_WORD);
   assign dbg_state = rst ? '0 : state;

   // The tag array is addressed by the latched request for the whole
   // operation; its contents for that set only change on a store hit or at
   // the end of a refill, so rd_tag still names the victim line throughout
   // the writeback.
   l1_tag_array #(
      .TAG_W (TAG_W),
      .IDX_W (IDX_W),
      .SETS  (SETS)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (req_idx),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .wr_en    (tag_we),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_dirty (tag_wr_dirty)
   );

   // Outputs and next state. Everything is forced to 0 while rst is high so
   // the interfaces are quiet during reset.
   always_comb begin
      state_d        = state;
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_data  = '0;
      dat_addr       = '0;
      dat_we         = 1'b0;
      dat_wdata      = '0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
      tag_we         = 1'b0;
      tag_wr_dirty   = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE: begin
               cpu_req_ready = 1'b1;
               // Start the SRAM read now so data is ready in LOOKUP.
               dat_addr = {cpu_idx, cpu_word};
               if (cpu_req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
               if (hit) begin
                  cpu_resp_valid = 1'b1;
                  if (req_we) begin
                     dat_we       = 1'b1;
                     dat_addr     = {req_idx, req_word};
                     dat_wdata    = req_wdata;
                     tag_we       = 1'b1;
                     tag_wr_dirty = 1'b1;
                  end else begin
                     cpu_resp_data = dat_rdata;
                  end
                  state_d = S_IDLE;
               end else if (rd_valid && rd_dirty) begin
                  state_d = S_WB_RD;
               end else begin
                  state_d = S_RF_REQ;
               end
            end
            S_WB_RD: begin
               dat_addr = {req_idx, cnt};
               state_d  = S_WB_REQ;
            end
            S_WB_REQ: begin
               mem_req_valid = 1'b1;
               mem_req_we    = 1'b1;
               mem_req_addr  = {rd_tag, req_idx, cnt, {BYTE_W{1'b0}}};
               // SRAM data is only guaranteed on the first WB_REQ cycle;
               // later cycles of a stalled beat use the captured copy.
               mem_req_wdata = wb_fresh ? dat_rdata : wb_data;
               if (mem_req_ready) state_d = cnt_last ? S_RF_REQ : S_WB_RD;
            end
            S_RF_REQ: begin
               mem_req_valid = 1'b1;
               mem_req_addr  = {req_tag, req_idx, cnt, {BYTE_W{1'b0}}};
               if (mem_req_ready) state_d = S_RF_WAIT;
            end
            S_RF_WAIT: begin
               if (mem_resp_valid) begin
                  dat_we    = 1'b1;
                  dat_addr  = {req_idx, cnt};
                  dat_wdata = mem_resp_data;
                  if (cnt_last) begin
                     tag_we  = 1'b1;
                     state_d = S_REPLAY;
                  end else begin
                     state_d = S_RF_REQ;
                  end
               end
            end
            S_REPLAY: begin
               dat_addr = {req_idx, req_word};
               state_d  = S_LOOKUP;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_we    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         wb_data   <= '0;
         wb_fresh  <= 1'b0;
      end else begin
         state    <= state_d;
         wb_fresh <= (state == S_WB_RD);
         if (state == S_WB_REQ && wb_fresh) wb_data <= dat_rdata;
         if (state == S_IDLE && cpu_req_valid) begin
            req_we    <= cpu_req_we;
            req_addr  <= cpu_req_addr[ADDR_W-1:BYTE_W];
            req_wdata <= cpu_req_wdata;
         end
         case (state)
            S_LOOKUP:  cnt <= '0;
            S_WB_REQ:  if (mem_req_ready)  cnt <= cnt_last ? '0 : cnt + 1'b1;
            S_RF_WAIT: if (mem_resp_valid) cnt <= cnt_last ? '0 : cnt + 1'b1;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: directed scenarios followed by random loads and
// stores. Expected results come from an architectural model (a flat memory
// image plus per-set tag/valid/dirty bookkeeping of a direct-mapped
// write-back cache) and from a memory agent that logs every bus beat.
module tb_l1_cache_ctrl;

   localparam int XLEN = 32, ADDR_W = 32, LINE_WORDS = 4, SETS = 64;
   localparam int DA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req_valid = 1'b0;
   logic              cpu_req_ready;
   logic              cpu_req_we = 1'b0;
   logic [31:0]       cpu_req_addr = '0;
   logic [31:0]       cpu_req_wdata = '0;
   logic              cpu_resp_valid;
   logic [31:0]       cpu_resp_data;
   logic [DA_W-1:0]   dat_addr;
   logic              dat_we;
   logic [31:0]       dat_wdata;
   logic [31:0]       dat_rdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [31:0]       mem_req_addr;
   logic [31:0]       mem_req_wdata;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_data;
   logic [2:0]        dbg_state;

   l1_cache_ctrl #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
      .dat_addr(dat_addr), .dat_we(dat_we), .dat_wdata(dat_wdata),
      .dat_rdata(dat_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- data SRAM model (1-cycle read) ----------------
   logic [31:0] sram [256];
   always @(posedge clk) begin
      if (dat_we) sram[dat_addr] <= dat_wdata;
      dat_rdata <= sram[dat_addr];
   end

   // ---------------- backing memory + reference model ----------------
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic [31:0] bk_mem [logic [31:0]];   // what memory actually holds
   logic [31:0] arch   [logic [31:0]];   // what a load must return
   int          ref_tag   [SETS];
   bit          ref_valid [SETS];
   bit          ref_dirty [SETS];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'h5EED0000;
   endfunction

   function automatic logic [31:0] bk_rd(input logic [31:0] a);
      return bk_mem.exists(a) ? bk_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] arch_rd(input logic [31:0] a);
      return arch.exists(a) ? arch[a] : init_val(a);
   endfunction

   function automatic logic [31:0] line_addr(input int tg, input int idx, input int w);
      return (32'(tg) << 10) | (32'(idx) << 4) | (32'(w) << 2);
   endfunction

   // ---------------- memory agent ----------------
   beat_t obs_q[$];
   int    rd_resp_cnt = 0;
   int    wb_beats = 0;
   int    resp_cd = -1;
   logic [31:0] resp_val;
   bit    rand_ready = 0;
   bit    stall_arm = 0;
   int    stall_left = 0;
   bit    stray_now = 0;
   bit    took = 0;
   beat_t took_b;
   bit    holding = 0;
   beat_t hold_b;

   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         if (took) begin
            obs_q.push_back(took_b);
            if (took_b.we) begin
               bk_mem[took_b.addr] = took_b.data;
               wb_beats++;
            end else begin
               resp_cd  = $urandom_range(0, 3);
               resp_val = bk_rd(took_b.addr);
            end
            took = 0;
         end
         if (resp_cd == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp_val;
            resp_cd = -1;
            rd_resp_cnt++;
         end else if (resp_cd > 0) begin
            resp_cd--;
         end
         if (stray_now) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hBAD0BAD0;
            stray_now = 0;
         end
         if (holding && !rst) begin
            check("hold_valid", 64'(mem_req_valid), 64'd1);
            check("hold_we",    64'(mem_req_we),    64'(hold_b.we));
            check("hold_addr",  64'(mem_req_addr),  64'(hold_b.addr));
            check("hold_wdata", 64'(mem_req_wdata), 64'(hold_b.data));
            check("busy_cpu_ready", 64'(cpu_req_ready), 64'd0);
         end
         if (stall_arm && mem_req_valid && mem_req_we && wb_beats == 2) begin
            stall_left = 5;
            stall_arm  = 0;
         end
         if (stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
         end else begin
            mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         holding = mem_req_valid && !mem_req_ready;
         hold_b  = '{we: mem_req_we, addr: mem_req_addr, data: mem_req_wdata};
         took    = mem_req_valid && mem_req_ready;
         took_b  = '{we: mem_req_we, addr: mem_req_addr,
                     data: mem_req_we ? mem_req_wdata : 32'h0};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         if (ref_valid[s] && ref_dirty[s]) begin
            // Stores not yet written back are lost by a reset.
            for (int w = 0; w < LINE_WORDS; w++)
               arch[line_addr(ref_tag[s], s, w)] = bk_rd(line_addr(ref_tag[s], s, w));
         end
         ref_valid[s] = 0;
         ref_dirty[s] = 0;
      end
   endtask

   task automatic do_reset(input bit chk);
      rst = 1'b1;
      cpu_req_valid = 1'b0;
      @(posedge clk); #2;
      if (chk) begin
         check("rst_cpu_ready", 64'(cpu_req_ready), 64'd0);
         check("rst_outputs", 64'({cpu_resp_valid, cpu_resp_data, dat_we, dat_addr,
               mem_req_valid, mem_req_we}), 64'd0);
         check("rst_wide_outputs", {mem_req_addr, mem_req_wdata | dat_wdata}, 64'd0);
      end
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #2;
      if (chk) check("post_rst_ready", 64'(cpu_req_ready), 64'd1);
   endtask

   task automatic cpu_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input string nm);
      beat_t       exp_q[$];
      logic [31:0] a;
      logic [31:0] exp_data;
      bit          exp_hit;
      bit          got;
      int          idx, tg, wd, lat, n;
      a   = {addr[31:2], 2'b00};
      idx = int'((a >> 4) & 32'h3F);
      wd  = int'((a >> 2) & 32'h3);
      tg  = int'(a >> 10);
      exp_hit = ref_valid[idx] && ref_tag[idx] == tg;
      if (!exp_hit) begin
         if (ref_valid[idx] && ref_dirty[idx])
            for (int w = 0; w < LINE_WORDS; w++)
               exp_q.push_back('{we: 1'b1, addr: line_addr(ref_tag[idx], idx, w),
                                 data: arch_rd(line_addr(ref_tag[idx], idx, w))});
         for (int w = 0; w < LINE_WORDS; w++)
            exp_q.push_back('{we: 1'b0, addr: line_addr(tg, idx, w), data: 32'h0});
         ref_tag[idx]   = tg;
         ref_valid[idx] = 1;
         ref_dirty[idx] = 0;
      end
      exp_data = arch_rd(a);
      if (we) begin
         arch[a] = wdata;
         ref_dirty[idx] = 1;
      end

      obs_q.delete();
      wb_beats = 0;
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (cpu_req_ready) got = 1;
         else begin @(posedge clk); #2; end
      end
      check({nm, "_accept"}, 64'(got), 64'd1);
      if (!got) begin do_reset(0); return; end
      @(posedge clk); #2;
      // Keep a bogus request pending while busy: it must not be taken.
      cpu_req_we    = 1'b1;
      cpu_req_addr  = $urandom;
      cpu_req_wdata = $urandom;
      lat = 1;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         if (cpu_resp_valid) got = 1;
         else begin @(posedge clk); #2; lat++; end
      end
      check({nm, "_resp"}, 64'(got), 64'd1);
      if (!got) begin do_reset(0); return; end
      if (we) begin
         check({nm, "_dat_we"},    64'(dat_we),    64'd1);
         check({nm, "_dat_addr"},  64'(dat_addr),  64'((idx << 2) | wd));
         check({nm, "_dat_wdata"}, 64'(dat_wdata), 64'(wdata));
      end else begin
         check({nm, "_data"}, 64'(cpu_resp_data), 64'(exp_data));
      end
      if (exp_hit) check({nm, "_hit_latency"}, 64'(lat), 64'd1);
      cpu_req_valid = 1'b0;
      check({nm, "_beat_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_beat%0d", nm, i), obs_q[i], exp_q[i]);
      @(posedge clk); #2;
      check({nm, "_resp_pulse"}, 64'({cpu_resp_valid, cpu_req_ready}), 64'b01);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      for (int s = 0; s < SETS; s++) begin
         ref_valid[s] = 0; ref_dirty[s] = 0; ref_tag[s] = 0;
      end
      for (int w = 0; w < 4; w++) begin
         bk_mem[32'h100 + 32'(w * 4)] = 32'hA0 + 32'(w);
         arch[32'h100 + 32'(w * 4)]   = 32'hA0 + 32'(w);
      end
      do_reset(1);

      cpu_op(0, 32'h100, 32'h0, "cold_ld_100");
      cpu_op(0, 32'h104, 32'h0, "hit_ld_104");
      cpu_op(1, 32'h108, 32'hDEADBEEF, "hit_st_108");
      cpu_op(0, 32'h108, 32'h0, "hit_ld_108");

      stall_arm = 1;
      cpu_op(0, 32'h1100, 32'h0, "evict_ld_1100");
      check("stall_applied", 64'(stall_arm), 64'd0);
      check("wb_mem_108", 64'(bk_rd(32'h108)), 64'hDEADBEEF);
      check("wb_mem_10c", 64'(bk_rd(32'h10C)), 64'hA3);

      cpu_op(1, 32'h2200, 32'h55, "miss_st_2200");
      cpu_op(0, 32'h2200, 32'h0, "ld_2200");
      cpu_op(0, 32'h3200, 32'h0, "evict_ld_3200");
      check("wb_mem_2200", 64'(bk_rd(32'h2200)), 64'h55);

      // Reset in the middle of a refill, then a stray response in IDLE.
      obs_q.delete();
      rd_resp_cnt   = 0;
      cpu_req_valid = 1'b1;
      cpu_req_we    = 1'b0;
      cpu_req_addr  = 32'h100;
      @(posedge clk); #2;
      cpu_req_valid = 1'b0;
      for (int i = 0; i < 200 && rd_resp_cnt < 2; i++) begin
         @(posedge clk); #2;
      end
      check("rst_mid_refill_beats", 64'(rd_resp_cnt >= 2), 64'd1);
      do_reset(0);
      stray_now = 1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #2;
         check("stray_ignored", 64'({cpu_resp_valid, mem_req_valid, cpu_req_ready}), 64'b001);
      end
      cpu_op(0, 32'h100, 32'h0, "ld_100_after_rst");

      // Random traffic over 4 tags x 4 sets to mix hits, clean and dirty misses.
      rand_ready = 1;
      for (int k = 0; k < 120; k++) begin
         logic [31:0] ra;
         ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         cpu_op(1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
